mioc_z80bus_gen: RTL and testbench

- Z80-side bus-cycle initiator that drives the buffered bus into the MIOC: BA, BD, BMREQ_N, IORQ_N, BRD_N, N_BWR, BM1_N and BRFSH_N.
- Answers BUSRQ_N with BUSAK_N, and honours WAIT_N.
- Serves as the stimulus/CPU-replacement end of the MIOC interface, in both the FPGA rebuild and the block-level benches.
- Accepts one command at a time over a valid/ready handshake and returns read data with a response pulse.

---
 rtl/mioc_pkg.sv | 48 ++++
 rtl/mioc_z80bus_gen_if.sv | 37 +++
 rtl/mioc_wait_ctr.sv | 23 ++
 rtl/mioc_z80bus_gen.sv | 222 ++++++++++++++++++++++
 tb/tb_mioc_z80bus_gen.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/mioc_pkg.sv
// rtl/mioc_pkg.sv - shared encodings for the MIOC Z80 bus-cycle generator
package mioc_pkg;

   typedef enum logic [2:0] {
      CMD_FETCH = 3'd0,
      CMD_MEMRD = 3'd1,
      CMD_MEMWR = 3'd2,
      CMD_IORD  = 3'd3,
      CMD_IOWR  = 3'd4
   } cmd_type_e;

   typedef enum logic [2:0] {
      ST_IDLE, ST_T1, ST_T2, ST_TW, ST_T3, ST_T4, ST_HOLD
   } bus_state_e;

   typedef struct packed {
      logic bmreq_n;
      logic iorq_n;
      logic brd_n;
      logic n_bwr;
      logic bm1_n;
      logic brfsh_n;
   } strobes_t;

   localparam strobes_t STROBES_IDLE = 6'b11_1111;
   localparam logic     BUSAK_IDLE   = 1'b1;

   function automatic logic is_mem(input logic [2:0] t);
      return (t == CMD_FETCH) || (t == CMD_MEMRD) || (t == CMD_MEMWR);
   endfunction

   function automatic logic is_io(input logic [2:0] t);
      return (t == CMD_IORD) || (t == CMD_IOWR);
   endfunction

   function automatic logic is_read(input logic [2:0] t);
      return (t == CMD_FETCH) || (t == CMD_MEMRD) || (t == CMD_IORD);
   endfunction

   function automatic logic is_write(input logic [2:0] t);
      return (t == CMD_MEMWR) || (t == CMD_IOWR);
   endfunction

   function automatic logic is_reserved(input logic [2:0] t);
      return t > CMD_IOWR;
   endfunction

endpackage

// File: rtl/mioc_z80bus_gen_if.sv
// rtl/mioc_z80bus_gen_if.sv - command/response handshake and buffered Z80 bus bundle
interface mioc_z80bus_gen_if;
   logic        CMD_VALID;
   logic        CMD_READY;
   logic [2:0]  CMD_TYPE;
   logic [15:0] CMD_ADDR;
   logic [7:0]  CMD_WDATA;
   logic        RSP_VALID;
   logic [7:0]  RSP_RDATA;
   logic        RSP_ERR;
   logic [15:0] BA;
   logic [7:0]  BD_IN;
   logic [7:0]  BD_OUT;
   logic        BD_OE;
   logic        BUS_OE;
   logic        BMREQ_N;
   logic        IORQ_N;
   logic        BRD_N;
   logic        N_BWR;
   logic        BM1_N;
   logic        BRFSH_N;
   logic        WAIT_N;
   logic        BUSRQ_N;
   logic        BUSAK_N;

   modport master (
      input  CMD_VALID, CMD_TYPE, CMD_ADDR, CMD_WDATA, BD_IN, WAIT_N, BUSRQ_N,
      output CMD_READY, RSP_VALID, RSP_RDATA, RSP_ERR, BA, BD_OUT, BD_OE, BUS_OE,
             BMREQ_N, IORQ_N, BRD_N, N_BWR, BM1_N, BRFSH_N, BUSAK_N
   );

   modport slave (
      output CMD_VALID, CMD_TYPE, CMD_ADDR, CMD_WDATA, BD_IN, WAIT_N, BUSRQ_N,
      input  CMD_READY, RSP_VALID, RSP_RDATA, RSP_ERR, BA, BD_OUT, BD_OE, BUS_OE,
             BMREQ_N, IORQ_N, BRD_N, N_BWR, BM1_N, BRFSH_N, BUSAK_N
   );
endinterface

// File: rtl/mioc_wait_ctr.sv
// rtl/mioc_wait_ctr.sv - loadable down-counter shared by IO auto-wait and wait timeout
module mioc_wait_ctr (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic [7:0] load_val,
   input  logic       dec,
   output logic       zero
);
   logic [7:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && (cnt != 8'd0)) begin
         cnt <= cnt - 8'd1;
      end
   end

   assign zero = (cnt == 8'd0);
endmodule

// File: rtl/mioc_z80bus_gen.sv
// rtl/mioc_z80bus_gen.sv - Z80-side bus-cycle initiator driving the buffered MIOC bus
module mioc_z80bus_gen
   import mioc_pkg::*;
#(
   parameter int WAIT_MAX    = 255,
   parameter int IO_AUTOWAIT = 1
) (
   input  logic              B_PHI,
   input  logic              RST_N,
   mioc_z80bus_gen_if.master bus
);
   localparam logic [7:0] WAIT_LOAD = 8'(WAIT_MAX - 1);
   localparam logic [7:0] AUTO_LOAD = 8'(IO_AUTOWAIT - 1);

   bus_state_e  state, state_nxt;
   logic        rel, rel_nxt;
   logic        auto_w, auto_nxt;
   logic [2:0]  c_type;
   logic [15:0] c_addr;
   logic [7:0]  c_wdata, r_reg, fetch_buf, rsp_rdata;
   logic        rsp_valid, rsp_err;
   logic        accept, finish, finish_err, fetch_cap, r_inc;
   logic        ctr_load, ctr_dec, ctr_zero;
   logic [7:0]  ctr_val;
   logic        fetch, mem, io, rd, wr, rsvd;
   strobes_t    stb;
   logic [15:0] ba;
   logic        bd_oe;

   assign fetch = (c_type == CMD_FETCH);
   assign mem   = is_mem(c_type);
   assign io    = is_io(c_type);
   assign rd    = is_read(c_type);
   assign wr    = is_write(c_type);
   assign rsvd  = is_reserved(c_type);

   mioc_wait_ctr u_wait_ctr (
      .clk      (B_PHI),
      .rst_n    (RST_N),
      .load     (ctr_load),
      .load_val (ctr_val),
      .dec      (ctr_dec),
      .zero     (ctr_zero)
   );

   always_ff @(posedge B_PHI or negedge RST_N) begin
      if (!RST_N) begin
         state  <= ST_IDLE;
         rel    <= 1'b0;
         auto_w <= 1'b0;
      end else begin
         state  <= state_nxt;
         rel    <= rel_nxt;
         auto_w <= auto_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      rel_nxt    = rel;
      auto_nxt   = auto_w;
      accept     = 1'b0;
      finish     = 1'b0;
      finish_err = 1'b0;
      fetch_cap  = 1'b0;
      r_inc      = 1'b0;
      ctr_load   = 1'b0;
      ctr_dec    = 1'b0;
      ctr_val    = '0;
      case (state)
         ST_IDLE: begin
            if (!bus.BUSRQ_N) begin
               state_nxt = ST_HOLD;
               rel_nxt   = 1'b0;
            end else if (bus.CMD_VALID) begin
               accept    = 1'b1;
               state_nxt = ST_T1;
            end
         end
         ST_T1: begin
            if (rsvd) begin
               finish     = 1'b1;
               finish_err = 1'b1;
            end else begin
               state_nxt = ST_T2;
            end
         end
         ST_T2: begin
            if (io && (IO_AUTOWAIT > 0)) begin
               state_nxt = ST_TW;
               auto_nxt  = 1'b1;
               ctr_load  = 1'b1;
               ctr_val   = AUTO_LOAD;
            end else if (!bus.WAIT_N) begin
               state_nxt = ST_TW;
               auto_nxt  = 1'b0;
               ctr_load  = 1'b1;
               ctr_val   = WAIT_LOAD;
            end else begin
               state_nxt = ST_T3;
               fetch_cap = fetch;
            end
         end
         ST_TW: begin
            // forced IO waits run out first; only then does WAIT_N arm the timeout
            if (auto_w && !ctr_zero) begin
               ctr_dec = 1'b1;
            end else if (!bus.WAIT_N) begin
               if (auto_w) begin
                  auto_nxt = 1'b0;
                  ctr_load = 1'b1;
                  ctr_val  = WAIT_LOAD;
               end else if (ctr_zero) begin
                  finish     = 1'b1;
                  finish_err = 1'b1;
               end else begin
                  ctr_dec = 1'b1;
               end
            end else begin
               state_nxt = ST_T3;
               fetch_cap = fetch;
            end
         end
         ST_T3: begin
            if (fetch) state_nxt = ST_T4;
            else       finish    = 1'b1;
         end
         ST_T4: begin
            finish = 1'b1;
            r_inc  = 1'b1;
         end
         ST_HOLD: begin
            if (rel) begin
               state_nxt = ST_IDLE;
               rel_nxt   = 1'b0;
            end else if (bus.BUSRQ_N) begin
               rel_nxt = 1'b1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
      if (finish) begin
         state_nxt = bus.BUSRQ_N ? ST_IDLE : ST_HOLD;
         rel_nxt   = 1'b0;
      end

      stb   = STROBES_IDLE;
      ba    = '0;
      bd_oe = 1'b0;
      case (state)
         ST_T1: begin
            stb.bm1_n = ~fetch;
            ba        = rsvd ? 16'h0000 : c_addr;
            bd_oe     = wr;
         end
         ST_T2, ST_TW: begin
            stb.bm1_n   = ~fetch;
            stb.bmreq_n = ~mem;
            stb.iorq_n  = ~io;
            stb.brd_n   = ~rd;
            stb.n_bwr   = ~wr;
            ba          = c_addr;
            bd_oe       = wr;
         end
         ST_T3: begin
            stb.bmreq_n = ~mem;
            stb.iorq_n  = ~io;
            stb.brd_n   = ~(rd & ~fetch);
            stb.n_bwr   = ~wr;
            stb.brfsh_n = ~fetch;
            ba          = fetch ? {8'h00, r_reg} : c_addr;
            bd_oe       = wr;
         end
         ST_T4: begin
            stb.brfsh_n = 1'b0;
            ba          = {8'h00, r_reg};
         end
         default: ;
      endcase
   end

   always_ff @(posedge B_PHI or negedge RST_N) begin
      if (!RST_N) begin
         c_type    <= '0;
         c_addr    <= '0;
         c_wdata   <= '0;
         r_reg     <= '0;
         fetch_buf <= '0;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         if (accept) begin
            c_type  <= bus.CMD_TYPE;
            c_addr  <= bus.CMD_ADDR;
            c_wdata <= bus.CMD_WDATA;
         end
         if (fetch_cap) fetch_buf <= bus.BD_IN;
         if (r_inc)     r_reg     <= {r_reg[7], r_reg[6:0] + 7'd1};
         rsp_valid <= finish;
         rsp_err   <= finish_err;
         // fetch data was latched entering T3; it is published with the response
         if (finish && !finish_err && rd) rsp_rdata <= fetch ? fetch_buf : bus.BD_IN;
      end
   end

   assign bus.CMD_READY = (state == ST_IDLE) && bus.BUSRQ_N;
   assign bus.RSP_VALID = rsp_valid;
   assign bus.RSP_RDATA = rsp_rdata;
   assign bus.RSP_ERR   = rsp_err;
   assign bus.BA        = ba;
   assign bus.BD_OE     = bd_oe;
   assign bus.BD_OUT    = bd_oe ? c_wdata : 8'h00;
   assign bus.BUS_OE    = (state != ST_HOLD);
   assign bus.BUSAK_N   = (state == ST_HOLD && !rel) ? 1'b0 : BUSAK_IDLE;
   assign bus.BMREQ_N   = stb.bmreq_n;
   assign bus.IORQ_N    = stb.iorq_n;
   assign bus.BRD_N     = stb.brd_n;
   assign bus.N_BWR     = stb.n_bwr;
   assign bus.BM1_N     = stb.bm1_n;
   assign bus.BRFSH_N   = stb.brfsh_n;
endmodule

// File: tb/tb_mioc_z80bus_gen.sv
// tb/tb_mioc_z80bus_gen.sv - directed self-checking bench for mioc_z80bus_gen
module tb_mioc_z80bus_gen;
   logic B_PHI;
   logic RST_N;
   int   checks;
   int   failures;
   int   rsp_at, n_mreq, n_iorq, n_rd, n_wr, n_m1, n_rfsh, n_oe, quiet;
   logic [15:0] ba_rf;
   logic [7:0]  wd;

   mioc_z80bus_gen_if bus_if ();

   mioc_z80bus_gen #(.WAIT_MAX(4), .IO_AUTOWAIT(1)) dut (
      .B_PHI (B_PHI),
      .RST_N (RST_N),
      .bus   (bus_if)
   );

   initial B_PHI = 1'b0;
   always #5 B_PHI = ~B_PHI;

   task automatic tick();
      @(posedge B_PHI);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [6:0] strobes();
      return {bus_if.BMREQ_N, bus_if.IORQ_N, bus_if.BRD_N, bus_if.N_BWR,
              bus_if.BM1_N, bus_if.BRFSH_N, bus_if.BUSAK_N};
   endfunction

   task automatic issue(input logic [2:0] t, input logic [15:0] a, input logic [7:0] d);
      bus_if.CMD_TYPE  = t;
      bus_if.CMD_ADDR  = a;
      bus_if.CMD_WDATA = d;
      bus_if.CMD_VALID = 1'b1;
      tick();
      bus_if.CMD_VALID = 1'b0;
   endtask

   // walks a cycle from T1; WAIT_N is low for the edges ending cycles wlo..whi
   task automatic watch(input int wlo, input int whi);
      rsp_at = -1; n_mreq = 0; n_iorq = 0; n_rd = 0; n_wr = 0;
      n_m1 = 0; n_rfsh = 0; n_oe = 0; ba_rf = 16'hFFFF; wd = 8'hFF;
      for (int i = 0; i < 40; i++) begin
         if (bus_if.RSP_VALID) begin
            rsp_at = i;
            break;
         end
         if (!bus_if.BMREQ_N) n_mreq++;
         if (!bus_if.IORQ_N)  n_iorq++;
         if (!bus_if.BRD_N)   n_rd++;
         if (!bus_if.N_BWR)   n_wr++;
         if (!bus_if.BM1_N)   n_m1++;
         if (!bus_if.BRFSH_N) begin n_rfsh++; ba_rf = bus_if.BA; end
         if (bus_if.BD_OE)    begin n_oe++; wd = bus_if.BD_OUT; end
         bus_if.WAIT_N = !(i >= wlo && i <= whi);
         tick();
      end
      bus_if.WAIT_N = 1'b1;
   endtask

   initial begin
      checks = 0;
      failures = 0;
      RST_N = 1'b0;
      bus_if.CMD_VALID = 1'b0; bus_if.CMD_TYPE = '0; bus_if.CMD_ADDR = '0;
      bus_if.CMD_WDATA = '0; bus_if.BD_IN = '0; bus_if.WAIT_N = 1'b1; bus_if.BUSRQ_N = 1'b1;
      tick(); tick();
      check("rst_strobes", strobes(), 7'h7F);
      check("rst_ba", bus_if.BA, 16'h0000);
      check("rst_oe", {bus_if.BD_OE, bus_if.BUS_OE, bus_if.BD_OUT}, {1'b0, 1'b1, 8'h00});
      check("rst_hs", {bus_if.RSP_VALID, bus_if.RSP_ERR, bus_if.RSP_RDATA, bus_if.CMD_READY},
            {1'b0, 1'b0, 8'h00, 1'b1});
      RST_N = 1'b1;
      tick();

      // mem read, no waits
      bus_if.BD_IN = 8'hA5;
      issue(3'd1, 16'h2000, 8'h00);
      check("rd_t1_ba", bus_if.BA, 16'h2000);
      watch(1, 0);
      check("rd_rsp_at", rsp_at, 3);
      check("rd_mreq", n_mreq, 2);
      check("rd_brd", n_rd, 2);
      check("rd_data", {bus_if.RSP_ERR, bus_if.RSP_RDATA}, {1'b0, 8'hA5});

      // IO write, one auto wait plus two WAIT_N waits
      issue(3'd4, 16'h007F, 8'h0F);
      check("iow_t1_ba", bus_if.BA, 16'h007F);
      watch(2, 3);
      check("iow_rsp_at", rsp_at, 6);
      check("iow_iorq", n_iorq, 5);
      check("iow_wr", n_wr, 5);
      check("iow_mreq", n_mreq, 0);
      check("iow_oe", n_oe, 6);
      check("iow_bdout", wd, 8'h0F);

      // wait timeout on mem read
      bus_if.BD_IN = 8'h11;
      issue(3'd1, 16'h4000, 8'h00);
      watch(0, 100);
      check("to_rsp_at", rsp_at, 6);
      check("to_mreq", n_mreq, 5);
      check("to_err", {bus_if.RSP_ERR, bus_if.RSP_RDATA}, {1'b1, 8'hA5});
      check("to_strobes", strobes(), 7'h7F);

      // reserved type
      issue(3'd5, 16'hBEEF, 8'h00);
      check("rsv_quiet", {strobes(), bus_if.BA}, {7'h7F, 16'h0000});
      watch(1, 0);
      check("rsv_rsp", {rsp_at[3:0], bus_if.RSP_ERR}, {4'd1, 1'b1});

      // bus request arriving during T2 of a mem write
      issue(3'd2, 16'h1234, 8'h5A);
      tick();
      bus_if.BUSRQ_N = 1'b0;
      tick();
      check("brq_t3", {bus_if.N_BWR, bus_if.BMREQ_N, bus_if.BUSAK_N}, 3'b001);
      tick();
      check("brq_end", {bus_if.RSP_VALID, bus_if.BUSAK_N, bus_if.BUS_OE, bus_if.CMD_READY, bus_if.BD_OE},
            5'b10000);
      tick();
      check("brq_hold", {bus_if.BUSAK_N, bus_if.BUS_OE}, 2'b00);
      bus_if.BUSRQ_N = 1'b1;
      tick();
      check("brq_rel", {bus_if.BUSAK_N, bus_if.BUS_OE, bus_if.CMD_READY}, 3'b100);
      tick();
      check("brq_idle", {bus_if.BUSAK_N, bus_if.BUS_OE, bus_if.CMD_READY}, 3'b111);

      // HOLD beats a simultaneous command
      bus_if.CMD_TYPE = 3'd1; bus_if.CMD_VALID = 1'b1; bus_if.BUSRQ_N = 1'b0;
      tick();
      check("sim_hold", {bus_if.BUSAK_N, bus_if.CMD_READY}, 2'b00);
      bus_if.CMD_VALID = 1'b0; bus_if.BUSRQ_N = 1'b1;
      quiet = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (bus_if.RSP_VALID || !bus_if.BMREQ_N) quiet++;
      end
      check("sim_noacc", quiet, 0);

      // asynchronous reset during a TW of an IO read
      issue(3'd3, 16'h0040, 8'h00);
      tick(); tick();
      check("rst_tw_iorq", bus_if.IORQ_N, 1'b0);
      #3 RST_N = 1'b0;
      #1 check("rst_async", {strobes(), bus_if.BUS_OE, bus_if.BA}, {7'h7F, 1'b1, 16'h0000});
      tick();
      check("rst_norsp", bus_if.RSP_VALID, 1'b0);
      RST_N = 1'b1;
      tick();
      bus_if.BD_IN = 8'h3C;
      issue(3'd1, 16'h0100, 8'h00);
      watch(1, 0);
      check("post_rst_rd", {rsp_at[3:0], bus_if.RSP_ERR, bus_if.RSP_RDATA}, {4'd3, 1'b0, 8'h3C});

      // step R up to 0x7F via fetches; refresh address shows R each time
      for (int k = 0; k < 127; k++) begin
         issue(3'd0, 16'(k), 8'h00);
         watch(1, 0);
         check("r_walk", ba_rf, 16'(k));
      end
      bus_if.BD_IN = 8'h3E;
      issue(3'd0, 16'h0000, 8'h00);
      watch(1, 0);
      check("f_rsp_at", rsp_at, 4);
      check("f_m1", n_m1, 2);
      check("f_rfsh", n_rfsh, 2);
      check("f_mreq_rd", {n_mreq[3:0], n_rd[3:0]}, {4'd2, 4'd1});
      check("f_ba_rfsh", ba_rf, 16'h007F);
      check("f_data", bus_if.RSP_RDATA, 8'h3E);
      bus_if.BD_IN = 8'h55;
      issue(3'd0, 16'h1234, 8'h00);
      watch(1, 0);
      check("f_r_wrap", ba_rf, 16'h0000);
      check("f_data2", bus_if.RSP_RDATA, 8'h55);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
